// File: rtl/sub_bytes_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sub_bytes_iter: iterative AES SubBytes/InvSubBytes, SBOX_LANES bytes/clk |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sub_bytes_iter #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] State_In,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] State_Out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] IDX_STEP = 4'(SBOX_LANES);
  localparam logic [3:0] IDX_LAST = 4'(16 - SBOX_LANES);

  // Entry b of each table lives at bits [8b +: 8] (entry 0 leftmost).
  localparam logic [0:2047] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[{b, 3'b000} +: 8] : FWD_SBOX[{b, 3'b000} +: 8];
  endfunction

  state_e       st_q;
  logic [3:0]   idx_q;
  logic         inv_q;
  logic [0:127] work_q;
  logic [0:127] work_d;
  logic [3:0]   lane_pos;

  // idx_q is always a multiple of SBOX_LANES, so the lane window never wraps.
  always_comb begin
    work_d   = work_q;
    lane_pos = idx_q;
    for (int l = 0; l < SBOX_LANES; l++) begin
      lane_pos = idx_q + 4'(l);
      work_d[{lane_pos, 3'b000} +: 8] = sub_byte(work_q[{lane_pos, 3'b000} +: 8], inv_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= S_IDLE;
      idx_q  <= 4'd0;
      inv_q  <= 1'b0;
      work_q <= '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (in_valid) begin
            work_q <= State_In;
            inv_q  <= inv_in;
            idx_q  <= 4'd0;
            st_q   <= S_SUB;
          end
        end
        S_SUB: begin
          work_q <= work_d;
          idx_q  <= idx_q + IDX_STEP;
          if (idx_q == IDX_LAST) begin
            st_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            st_q <= S_IDLE;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (st_q == S_IDLE);
  assign busy      = (st_q == S_SUB);
  assign out_valid = (st_q == S_DONE);
  assign State_Out = work_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// Directed bench for sub_bytes_iter: one instance per legal SBOX_LANES value
// sharing stimulus; instance 2 (4 lanes) carries the detailed scenarios.
module tb_sub_bytes_iter;

  localparam int NDUT = 5;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL00    = {16{8'h00}};
  localparam logic [127:0] ALLFF    = {16{8'hff}};
  localparam logic [127:0] ALL63    = {16{8'h63}};
  localparam logic [127:0] ALL16    = {16{8'h16}};
  localparam logic [127:0] ALL53    = {16{8'h53}};
  localparam logic [127:0] ALLED    = {16{8'hed}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            in_valid;
  logic            inv_in;
  logic            out_ready;
  logic [0:127]    State_In;
  logic [NDUT-1:0] ir;
  logic [NDUT-1:0] ov;
  logic [NDUT-1:0] bz;
  logic [0:127]    so [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sub_bytes_iter #(.SBOX_LANES(1 << g)) u_dut (
        .clock    (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (ir[g]),
        .State_In (State_In),
        .inv_in   (inv_in),
        .out_valid(ov[g]),
        .out_ready(out_ready),
        .State_Out(so[g]),
        .busy     (bz[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && !(&ir); k++) tick();
    check("idle_wait", 128'(&ir), 128'(1'b1));
  endtask

  // Present one state for a single accept edge with out_ready high and
  // return the result of instance g and its accept-to-out_valid latency.
  task automatic xfer(input int g, input logic [127:0] din, input logic inv,
                      output logic [127:0] dout, output int lat);
    wait_idle();
    State_In  = din;
    inv_in    = inv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    State_In = '0;
    inv_in   = ~inv;
    lat  = -1;
    dout = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ov[g]) begin
        lat  = k;
        dout = so[g];
        break;
      end
    end
    tick();
  endtask

  logic [127:0]    res;
  logic [127:0]    snap;
  int              lat;
  logic            stable;
  logic            ir_low;
  logic            seen;
  int              first_t [NDUT];
  int              second_t[NDUT];
  logic [NDUT-1:0] prev_bz;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    inv_in    = 1'b0;
    out_ready = 1'b0;
    State_In  = '0;

    #2 reset = 1'b0;
    #1;
    check("rst_in_ready", 128'(ir[2]), 128'(1'b1));
    check("rst_out_valid", 128'(ov[2]), 128'(1'b0));
    check("rst_busy", 128'(bz[2]), 128'(1'b0));
    check("rst_state_out", so[2], ALL00);
    tick();
    tick();
    reset = 1'b1;

    xfer(2, FIPS_IN, 1'b0, res, lat);
    check("fwd_fips", res, FIPS_OUT);
    check("fwd_latency", 128'(lat), 128'(4));
    xfer(2, FIPS_OUT, 1'b1, res, lat);
    check("inv_fips", res, FIPS_IN);
    xfer(2, ALL00, 1'b0, res, lat);
    check("fwd_00", res, ALL63);
    xfer(2, ALLFF, 1'b0, res, lat);
    check("fwd_ff", res, ALL16);
    xfer(2, ALL63, 1'b1, res, lat);
    check("inv_63", res, ALL00);

    for (int g = 0; g < NDUT; g++) begin
      if (g == 2) continue;
      xfer(g, FIPS_IN, 1'b0, res, lat);
      check($sformatf("sweep_data_L%0d", 1 << g), res, FIPS_OUT);
      check($sformatf("sweep_lat_L%0d", 1 << g), 128'(lat), 128'(16 >> g));
    end

    // Back-pressure with input churn while DONE is held.
    wait_idle();
    State_In  = FIPS_IN;
    inv_in    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ov[2]) begin
        lat = k;
        break;
      end
    end
    check("bp_latency", 128'(lat), 128'(4));
    snap   = so[2];
    stable = 1'b1;
    ir_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      State_In = {$urandom, $urandom, $urandom, $urandom};
      in_valid = i[0];
      inv_in   = ~i[0];
      tick();
      if (so[2] !== snap) stable = 1'b0;
      if (ir[2] !== 1'b0 || ov[2] !== 1'b1) ir_low = 1'b0;
    end
    check("bp_result", snap, FIPS_OUT);
    check("bp_hold_stable", 128'(stable), 128'(1'b1));
    check("bp_in_ready_low", 128'(ir_low), 128'(1'b1));

    // in_valid and out_ready together in DONE: output handshake only.
    State_In  = ALL53;
    inv_in    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rel_in_ready", 128'(ir[2]), 128'(1'b1));
    check("rel_out_valid", 128'(ov[2]), 128'(1'b0));
    check("rel_no_accept", 128'(bz[2]), 128'(1'b0));
    tick();
    in_valid = 1'b0;
    check("rel_accept_next", 128'(bz[2]), 128'(1'b1));
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ov[2]) begin
        lat = k;
        res = so[2];
        break;
      end
    end
    check("fwd_53", res, ALLED);
    check("fwd_53_latency", 128'(lat), 128'(4));
    tick();

    // Reset two cycles into SUB.
    wait_idle();
    State_In  = FIPS_IN;
    inv_in    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 128'(bz[2]), 128'(1'b1));
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(ov[2]), 128'(1'b0));
    check("mid_rst_busy", 128'(bz[2]), 128'(1'b0));
    check("mid_rst_in_ready", 128'(ir[2]), 128'(1'b1));
    check("mid_rst_state_out", so[2], ALL00);
    tick();
    reset = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (|ov) seen = 1'b1;
    end
    check("abort_no_out_valid", 128'(seen), 128'(1'b0));
    check("abort_all_idle", 128'(ir), 128'({NDUT{1'b1}}));

    // Back-to-back inputs: spacing between successive accepts.
    wait_idle();
    State_In  = FIPS_IN;
    inv_in    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_bz   = bz;
    for (int g = 0; g < NDUT; g++) begin
      first_t[g]  = -1;
      second_t[g] = -1;
    end
    for (int t = 1; t <= 60; t++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        if (bz[g] && !prev_bz[g]) begin
          if (first_t[g] < 0) first_t[g] = t;
          else if (second_t[g] < 0) second_t[g] = t;
        end
      end
      prev_bz = bz;
    end
    in_valid = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("ii_L%0d", 1 << g),
            128'((second_t[g] < 0) ? -1 : second_t[g] - first_t[g]),
            128'((16 >> g) + 2));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative SubBytes / InvSubBytes stage. It sits directly upstream of shift_rows in the round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes SBOX_LANES bytes per clock through shared S-box lookups. It then presents the substituted state to the next stage until that stage accepts it. The `inv` flag, captured with each state, selects the forward S-box (encryption) or the inverse S-box (decryption).

## Interface
- SBOX_LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  State_In/inv_in valid
- in_ready  output  1  block can accept a state
- State_In  input  [0:127]  input state; byte k = bits [8k +: 8], byte 0 = bits [0:7]
- inv_in  input  1  0 = SubBytes, 1 = InvSubBytes
- out_valid  output  1  State_Out holds a completed result
- out_ready  input  1  downstream accepts State_Out
- State_Out  output  [0:127]  substituted state, same byte order as State_In
- busy  output  1  substitution in progress

## Operation
- Three-state FSM: IDLE, SUB, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid&&in_ready: load State_In into the working register, latch inv_in into inv_q, clear byte index idx=0, go to SUB.
- SUB:
  - in_ready=0, busy=1.
  - Each cycle, bytes idx .. idx+SBOX_LANES-1 of the working register are replaced by S(byte), or S⁻¹(byte) when inv_q=1.
  - idx advances by SBOX_LANES.
  - After the cycle that processes byte 15, go to DONE.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - State_Out is held stable.
  - On out_ready=1: go to IDLE. out_valid drops after that edge.
- State_Out is driven directly from the working register. Downstream may sample it only while out_valid=1.
- Both S-box tables are internal constant functions of the FIPS-197 tables. No memory initialisation files.
- inv_in and State_In are ignored outside the IDLE accept cycle. Changing them mid-operation has no effect.
- idx width is 4 bits and wraps to 0 on leaving SUB. idx is never compared past 15.
- in_valid while not in IDLE is not accepted. Upstream must hold in_valid and data until in_ready=1.

## Timing
- Reset (reset=0, asynchronous, any state, including mid-SUB or DONE):
  - FSM=IDLE, idx=0, working register=128'h0, inv_q=0.
  - out_valid=0, busy=0, in_ready=1 (asserts immediately while reset is low).
  - Any in-flight state is discarded. No out_valid is produced for it.
- Release of reset is synchronised by the user. The first accept may occur on the first rising edge with reset=1.
- Latency, with N = 16/SBOX_LANES:
  - Accept at edge 0; SUB occupies edges 1..N; out_valid=1 after edge N.
  - Default N=4: accept edge 0 → out_valid high after edge 4.
- out_ready already high when out_valid rises: handshake completes on that next edge; in_ready=1 one cycle later. Minimum initiation interval is N+2 cycles.
- out_ready low: DONE persists indefinitely with State_Out unchanged (back-pressure).
- in_valid and out_ready both high in DONE: only the output handshake occurs. The input is accepted in the following IDLE cycle.
- in_ready, out_valid and busy are pure decodes of the FSM register. No combinational path from in_valid or out_ready to any output.

## Test plan
- Reset mid-flight:
  - Stimulus: accept a state, assert reset=0 two cycles into SUB.
  - Required: out_valid=0, busy=0, in_ready=1 and State_Out=0 asynchronously, before the next edge.
  - Required after release: no out_valid ever appears for the aborted state.
- FIPS-197 forward vector (SBOX_LANES=4, inv_in=0):
  - Stimulus: State_In=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1.
  - Required: out_valid high exactly 4 cycles after accept; State_Out=d42711aee0bf98f1b8b45de51e415230.
- Inverse vector:
  - Stimulus: inv_in=1, State_In=d42711aee0bf98f1b8b45de51e415230.
  - Required: State_Out=193de3bea0f4e22b9ac68d2ae9f84808.
- Table corners:
  - Stimulus: State_In=00…00, then FF…FF, then 53 in every byte (forward).
  - Required: 63…63, 16…16, ED…ED.
  - Stimulus: inverse of 63…63.
  - Required: 00…00.
- Back-pressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises; toggle State_In/in_valid meanwhile.
  - Required: State_Out stable, in_ready=0 throughout.
  - Required after out_ready=1: in_ready=1 one cycle later.
- Parameter sweep:
  - Stimulus: repeat the forward vector with SBOX_LANES=1, 2, 8, 16.
  - Required: identical State_Out; accept-to-out_valid latency = 16, 8, 2, 1 cycles respectively.
  - Stimulus: back-to-back inputs.
  - Required: initiation interval = N+2.
